// File: rtl/uart_phy_cfg_if.sv
// Serial pins plus the word-side transmit handshake and receive result signals of the UART PHY.
// The master side is the protocol logic; the slave side is the PHY.
interface uart_phy_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 tx;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output rx, tx_data, tx_valid,
    input  tx, tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  rx, tx_data, tx_valid,
    output tx, tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_phy_cfg.sv
// Parametrised UART PHY: 16x oversampled RX with 3-sample majority vote, valid/ready TX, frame/parity errors.
// Optional parity bit compiled in with `define UART_PHY_PARITY_EN (sense from PARITY_ODD).
module uart_phy_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic clk,
  input logic arstn,
  uart_phy_cfg_if.slave bus
);
  localparam int DIV = CLK_FREQ / (16 * BAUDRATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], bus.rx};
  end
  assign rx_s = rx_sync[1];

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PHY_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t            rx_state;
  logic [3:0]           rx_phase;
  logic                 s7, s8;
  logic [BW-1:0]        rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, rx_ferr_r, rx_perr_r, rx_perr_acc;
  logic                 rx_bit;

  // Majority of the tick-7/8 samples and the live tick-9 sample.
  assign rx_bit = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_state    <= RX_IDLE;
      rx_phase    <= '0;
      s7          <= 1'b1;
      s8          <= 1'b1;
      rx_cnt      <= '0;
      rx_shift    <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      rx_ferr_r   <= 1'b0;
      rx_perr_r   <= 1'b0;
      rx_perr_acc <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (!rx_s) begin
          rx_state    <= RX_START;
          rx_phase    <= '0;
          rx_perr_acc <= 1'b0;
        end
      end else if (rx_state == RX_WAIT_HIGH) begin
        if (rx_s) rx_state <= RX_IDLE;
      end else if (tick) begin
        rx_phase <= rx_phase + 4'd1;
        if (rx_phase == 4'd7) s7 <= rx_s;
        if (rx_phase == 4'd8) s8 <= rx_s;
        case (rx_state)
          RX_START: begin
            rx_cnt <= '0;
            if (rx_phase == 4'd9 && rx_bit) rx_state <= RX_IDLE;
            else if (rx_phase == 4'd15)     rx_state <= RX_DATA;
          end
          RX_DATA: begin
            if (rx_phase == 4'd9) rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
            if (rx_phase == 4'd15) begin
              rx_cnt <= rx_cnt + 1'b1;
              if (rx_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_PHY_PARITY_EN
                rx_state <= RX_PARITY;
`else
                rx_state <= RX_STOP;
`endif
              end
            end
          end
`ifdef UART_PHY_PARITY_EN
          RX_PARITY: begin
            if (rx_phase == 4'd9)  rx_perr_acc <= rx_bit ^ (^rx_shift) ^ 1'(PARITY_ODD);
            if (rx_phase == 4'd15) rx_state <= RX_STOP;
          end
`endif
          RX_STOP: begin
            if (rx_phase == 4'd9) begin
              rx_data_r  <= rx_shift;
              rx_ferr_r  <= ~rx_bit;
              rx_perr_r  <= rx_perr_acc;
              rx_valid_r <= 1'b1;
              rx_state   <= rx_bit ? RX_IDLE : RX_WAIT_HIGH;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data      = rx_data_r;
  assign bus.rx_valid     = rx_valid_r;
  assign bus.rx_frame_err = rx_ferr_r;
`ifdef UART_PHY_PARITY_EN
  assign bus.rx_parity_err = rx_perr_r;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PHY_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t            tx_state;
  logic [DW-1:0]        tx_div;
  logic [3:0]           tx_phase;
  logic [BW-1:0]        tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_r, tx_ready_r, tx_line, tx_bit_end;

  // TX restarts its own divider on acceptance so every bit, start included, is exactly 16*DIV clocks.
  assign tx_bit_end = (tx_div == DIV_MAX) && (tx_phase == 4'd15);

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift[0];
`ifdef UART_PHY_PARITY_EN
      TX_PARITY: tx_line = tx_par;
`endif
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_state   <= TX_IDLE;
      tx_div     <= '0;
      tx_phase   <= '0;
      tx_cnt     <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
    end else begin
      tx_r <= tx_line;
      if (tx_state == TX_IDLE) begin
        if (bus.tx_valid) begin
          tx_shift   <= bus.tx_data;
          tx_par     <= (^bus.tx_data) ^ 1'(PARITY_ODD);
          tx_ready_r <= 1'b0;
          tx_state   <= TX_START;
          tx_div     <= '0;
          tx_phase   <= '0;
        end
      end else begin
        tx_div <= (tx_div == DIV_MAX) ? '0 : tx_div + 1'b1;
        if (tx_div == DIV_MAX) tx_phase <= tx_phase + 4'd1;
        if (tx_bit_end) begin
          case (tx_state)
            TX_START: begin
              tx_state <= TX_DATA;
              tx_cnt   <= '0;
            end
            TX_DATA: begin
              tx_shift <= tx_shift >> 1;
              if (tx_cnt == BW'(DATA_BITS - 1)) begin
                tx_cnt <= '0;
`ifdef UART_PHY_PARITY_EN
                tx_state <= TX_PARITY;
`else
                tx_state <= TX_STOP;
`endif
              end else begin
                tx_cnt <= tx_cnt + 1'b1;
              end
            end
`ifdef UART_PHY_PARITY_EN
            TX_PARITY: tx_state <= TX_STOP;
`endif
            TX_STOP: begin
              if (tx_cnt == BW'(STOP_BITS - 1)) begin
                tx_state   <= TX_IDLE;
                tx_ready_r <= 1'b1;
              end else begin
                tx_cnt <= tx_cnt + 1'b1;
              end
            end
            default: tx_state <= TX_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.tx       = tx_r;
  assign bus.tx_ready = tx_ready_r;
endmodule

// File: tb/tb_uart_phy_cfg.sv
// Bench for uart_phy_cfg: 8N1 instance (with switchable loopback) and a 5-data/2-stop instance in loopback.
// Expected frames come from a bit-list model of the UART frame format.
module tb_uart_phy_cfg;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = 160;
`ifdef UART_PHY_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic loop = 1'b0;
  logic rx_drv = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_phy_cfg_if #(.DATA_BITS(8)) u ();
  uart_phy_cfg_if #(.DATA_BITS(5)) u5 ();

  assign u.rx  = loop ? u.tx : rx_drv;
  assign u5.rx = u5.tx;

  uart_phy_cfg #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0))
    dut (.clk(clk), .arstn(arstn), .bus(u.slave));
  uart_phy_cfg #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0))
    dut5 (.clk(clk), .arstn(arstn), .bus(u5.slave));

  logic [7:0] q_d[$];
  logic       q_f[$];
  logic       q_p[$];
  logic [4:0] q5[$];

  always @(negedge clk) begin
    if (u.rx_valid === 1'b1) begin
      q_d.push_back(u.rx_data);
      q_f.push_back(u.rx_frame_err);
      q_p.push_back(u.rx_parity_err);
    end
    if (u5.rx_valid === 1'b1) q5.push_back(u5.rx_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void clear_q();
    q_d.delete(); q_f.delete(); q_p.delete(); q5.delete();
  endfunction

  // Line level per bit slot: start, data LSB first, even parity if present, then high.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nb);
    logic [15:0] f;
    logic p;
    f = '1;
    p = 1'b0;
    f[0] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[1+i] = d[i];
      p ^= d[i];
    end
    if (PB == 1) f[1+nb] = p;
    return f;
  endfunction

  task automatic tx_check(input bit w5, input logic [8:0] d, input int nb, input int ns, input string name);
    logic [15:0] f;
    int n, bad, rdy_low, k;
    logic t, r;
    f = frame_bits(d, nb);
    n = 1 + nb + PB + ns;
    k = 0;
    while (((w5 ? u5.tx_ready : u.tx_ready) !== 1'b1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_ready_wait"}, 32'(k < 5000), 1);
    @(negedge clk);
    if (w5) begin u5.tx_valid = 1'b1; u5.tx_data = d[4:0]; end
    else    begin u.tx_valid  = 1'b1; u.tx_data  = d[7:0]; end
    @(posedge clk);
    #1;
    if (w5) begin u5.tx_valid = 1'b0; u5.tx_data = ~d[4:0]; end
    else    begin u.tx_valid  = 1'b0; u.tx_data  = ~d[7:0]; end
    bad = 0;
    rdy_low = 0;
    r = 1'b0;
    for (int c = 0; c <= n * BIT; c++) begin
      @(negedge clk);
      t = w5 ? u5.tx : u.tx;
      r = w5 ? u5.tx_ready : u.tx_ready;
      if (t !== ((c == 0) ? 1'b1 : f[(c-1)/BIT])) bad++;
      if (r === 1'b0) rdy_low++;
    end
    chk({name, "_wave_errs"}, bad, 0);
    chk({name, "_ready_low_clks"}, rdy_low, n * BIT);
    chk({name, "_ready_back"}, r, 1);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic par, input logic stop);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (PB == 1) begin
      rx_drv = par;
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stop;
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic rx_expect(input string name, input logic [7:0] ed, input logic ef, input logic ep);
    chk({name, "_rx_count"}, q_d.size(), 1);
    chk({name, "_rx_data"}, (q_d.size() > 0) ? q_d[0] : 8'hxx, ed);
    chk({name, "_frame_err"}, (q_f.size() > 0) ? q_f[0] : 1'bx, ef);
    chk({name, "_parity_err"}, (q_p.size() > 0) ? q_p[0] : 1'bx, ep);
    clear_q();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_f;
  } rxvec_t;

  initial begin
    rxvec_t vt[4];
    logic [7:0] b;
    logic st, pb;
    int c;

    vt[0] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    vt[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vt[3] = '{8'h81, 1'b0, 8'h81, 1'b1};

    u.tx_valid = 1'b0;  u.tx_data = '0;
    u5.tx_valid = 1'b0; u5.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", u.tx, 1);
    chk("rst_tx_ready", u.tx_ready, 1);
    chk("rst_rx_valid", u.rx_valid, 0);
    chk("rst_rx_data", u.rx_data, 0);
    chk("rst_frame_err", u.rx_frame_err, 0);
    chk("rst_parity_err", u.rx_parity_err, 0);
    chk("rst_tx5_ready", u5.tx_ready, 1);
    arstn = 1'b1;
    repeat (5) @(negedge clk);

    tx_check(1'b0, 9'h0A5, 8, 1, "tx_a5");

    loop = 1'b1;
    clear_q();
    tx_check(1'b0, 9'h03C, 8, 1, "loop_3c");
    repeat (200) @(negedge clk);
    rx_expect("loop_3c", 8'h3C, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_check(1'b0, {1'b0, b}, 8, 1, "rand_loop");
      repeat (200) @(negedge clk);
      rx_expect("rand_loop", b, 1'b0, 1'b0);
    end

    // Held-high tx_valid: ready returns 1600 clks after acceptance, one idle clk, then next start bit.
    @(negedge clk);
    u.tx_valid = 1'b1; u.tx_data = 8'h12;
    @(posedge clk);
    #1;
    c = 0;
    while (u.tx_ready !== 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_ready_return", c, 10 * BIT + PB * BIT + 1);
    chk("b2b_idle_tx", u.tx, 1);
    @(negedge clk);
    chk("b2b_reaccept", u.tx_ready, 0);
    chk("b2b_idle_clk_tx", u.tx, 1);
    @(negedge clk);
    chk("b2b_second_start", u.tx, 0);
    u.tx_valid = 1'b0;
    c = 0;
    while (u.tx_ready !== 1'b1 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (300) @(negedge clk);
    clear_q();
    loop = 1'b0;

    foreach (vt[i]) begin
      rx_send(vt[i].d, ^vt[i].d, vt[i].stop);
      repeat (20) @(negedge clk);
      rx_expect("rx_table", vt[i].exp_d, vt[i].exp_f, 1'b0);
    end

    rx_drv = 1'b0;
    repeat (50) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_no_valid", q_d.size(), 0);
    rx_send(8'hA3, ^8'hA3, 1'b1);
    rx_expect("after_glitch", 8'hA3, 1'b0, 1'b0);

    rx_drv = 1'b0;
    repeat (BIT * (10 + PB + 20)) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    rx_expect("break", 8'h00, 1'b1, 1'b0);
    rx_send(8'h55, ^8'h55, 1'b1);
    rx_expect("after_break", 8'h55, 1'b0, 1'b0);

`ifdef UART_PHY_PARITY_EN
    rx_send(8'h07, 1'b0, 1'b1);
    rx_expect("par_bad", 8'h07, 1'b0, 1'b1);
    rx_send(8'h07, 1'b1, 1'b1);
    rx_expect("par_good", 8'h07, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom_range(0, 255));
      st = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      rx_send(b, pb, st);
      repeat (20) @(negedge clk);
      rx_expect("rand_rx", b, ~st, (PB == 1) ? (pb != ^b) : 1'b0);
    end

    clear_q();
    tx_check(1'b1, 9'h01F, 5, 2, "tx5_1f");
    repeat (200) @(negedge clk);
    chk("tx5_rx_count", q5.size(), 1);
    chk("tx5_rx_data", (q5.size() > 0) ? q5[0] : 5'hxx, 5'h1F);

    // Reset in the middle of a zero-data frame: tx must return high and ready immediately.
    @(negedge clk);
    u.tx_valid = 1'b1; u.tx_data = 8'h00;
    @(posedge clk);
    #1;
    u.tx_valid = 1'b0;
    repeat (300) @(negedge clk);
    chk("midframe_tx_low", u.tx, 0);
    arstn = 1'b0;
    #1;
    chk("midrst_tx", u.tx, 1);
    chk("midrst_ready", u.tx_ready, 1);
    @(negedge clk);
    arstn = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    chk("postrst_tx_idle", u.tx, 1);
    chk("postrst_ready", u.tx_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
